// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - op encodings, FSM states and constants for the multiply/divide unit
package muldiv_pkg;

  localparam logic [2:0] OP_MULTU = 3'd0;
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_DIVU  = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  // Quotient returned on divide-by-zero; sliced to WIDTH by the user (WIDTH <= 64)
  localparam logic [63:0] DIVZ_LO = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    FIX  = 2'd3
  } state_t;

endpackage

// File: rtl/muldiv_if.sv
// rtl/muldiv_if.sv - request/result bundle between the CPU core and the multiply/divide unit
interface muldiv_if #(parameter int WIDTH = 32);

  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, op, a, b, input busy, done, hi, lo);
  modport slave  (input start, op, a, b, output busy, done, hi, lo);

endinterface

// File: rtl/muldiv_abs.sv
// rtl/muldiv_abs.sv - conditional two's-complement negation, used both to take magnitudes
// of signed operands and to restore the sign of results
module muldiv_abs #(
  parameter int W = 32
) (
  input  logic [W-1:0] i_val,
  input  logic         i_neg,
  output logic [W-1:0] o_val
);

  assign o_val = i_neg ? -i_val : i_val;

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative shift-add multiplier / restoring divider with HI/LO registers
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic   clk,
  input  logic   rst,
  muldiv_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  state_t               r_state, w_state_nxt;
  logic [CNT_W-1:0]     r_cnt, w_cnt_nxt;
  logic [2*WIDTH-1:0]   r_acc, w_acc_nxt;
  logic [WIDTH-1:0]     r_opnd, w_opnd_nxt;
  logic                 r_sign_lo, w_sign_lo_nxt;
  logic                 r_sign_hi, w_sign_hi_nxt;
  logic                 r_is_div, w_is_div_nxt;
  logic                 r_divz, w_divz_nxt;
  logic                 r_busy, w_busy_nxt;
  logic                 r_done, w_done_nxt;
  logic [WIDTH-1:0]     r_hi, w_hi_nxt;
  logic [WIDTH-1:0]     r_lo, w_lo_nxt;

  logic                 w_sgn_op;
  logic [WIDTH-1:0]     w_mag_a, w_mag_b;
  logic [WIDTH:0]       w_sum, w_tmp, w_diff;
  logic [2*WIDTH-1:0]   w_mul_acc, w_div_acc, w_fix_prod;
  logic [WIDTH-1:0]     w_fix_q, w_fix_r;

  assign w_sgn_op = (bus.op == OP_MULT) || (bus.op == OP_DIV);

  muldiv_abs #(.W(WIDTH)) u_abs_a (.i_val(bus.a), .i_neg(w_sgn_op & bus.a[WIDTH-1]), .o_val(w_mag_a));
  muldiv_abs #(.W(WIDTH)) u_abs_b (.i_val(bus.b), .i_neg(w_sgn_op & bus.b[WIDTH-1]), .o_val(w_mag_b));

  muldiv_abs #(.W(2*WIDTH)) u_fix_prod (.i_val(r_acc), .i_neg(r_sign_lo), .o_val(w_fix_prod));
  muldiv_abs #(.W(WIDTH)) u_fix_q (.i_val(r_acc[WIDTH-1:0]), .i_neg(r_sign_lo), .o_val(w_fix_q));
  muldiv_abs #(.W(WIDTH)) u_fix_r (.i_val(r_acc[2*WIDTH-1:WIDTH]), .i_neg(r_sign_hi), .o_val(w_fix_r));

  // Multiply: acc = {partial product, remaining multiplier bits}, add then shift right
  assign w_sum     = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_opnd};
  assign w_mul_acc = r_acc[0] ? {w_sum, r_acc[WIDTH-1:1]} : {1'b0, r_acc[2*WIDTH-1:1]};

  // Divide: acc = {partial remainder, dividend bits / quotient bits}, shift left then try subtract
  assign w_tmp     = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
  assign w_diff    = w_tmp - {1'b0, r_opnd};
  assign w_div_acc = w_diff[WIDTH] ? {w_tmp[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                                   : {w_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_acc_nxt     = r_acc;
    w_opnd_nxt    = r_opnd;
    w_sign_lo_nxt = r_sign_lo;
    w_sign_hi_nxt = r_sign_hi;
    w_is_div_nxt  = r_is_div;
    w_divz_nxt    = r_divz;
    w_busy_nxt    = r_busy;
    w_done_nxt    = 1'b0;
    w_hi_nxt      = r_hi;
    w_lo_nxt      = r_lo;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          case (bus.op)
            OP_MULTU, OP_MULT: begin
              w_state_nxt   = MUL;
              w_busy_nxt    = 1'b1;
              w_cnt_nxt     = '0;
              w_opnd_nxt    = w_mag_a;
              w_acc_nxt     = {{WIDTH{1'b0}}, w_mag_b};
              w_sign_lo_nxt = w_sgn_op & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
              w_sign_hi_nxt = w_sgn_op & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
              w_is_div_nxt  = 1'b0;
              w_divz_nxt    = 1'b0;
            end
            OP_DIVU, OP_DIV: begin
              w_state_nxt   = DIV;
              w_busy_nxt    = 1'b1;
              w_cnt_nxt     = '0;
              w_opnd_nxt    = w_mag_b;
              w_acc_nxt     = {{WIDTH{1'b0}}, w_mag_a};
              w_sign_lo_nxt = w_sgn_op & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
              w_sign_hi_nxt = w_sgn_op & bus.a[WIDTH-1];
              w_is_div_nxt  = 1'b1;
              w_divz_nxt    = (bus.b == '0);
            end
            OP_MTHI: w_hi_nxt = bus.a;
            OP_MTLO: w_lo_nxt = bus.a;
            default: ;
          endcase
        end
      end
      MUL, DIV: begin
        w_acc_nxt = (r_state == MUL) ? w_mul_acc : w_div_acc;
        w_cnt_nxt = r_cnt + CNT_W'(1);
        if (r_cnt == CNT_W'(WIDTH - 1)) w_state_nxt = FIX;
      end
      FIX: begin
        // A zero divisor leaves the dividend magnitude as remainder, so only LO needs forcing
        if (r_is_div) begin
          w_hi_nxt = w_fix_r;
          w_lo_nxt = r_divz ? DIVZ_LO[WIDTH-1:0] : w_fix_q;
        end else begin
          w_hi_nxt = w_fix_prod[2*WIDTH-1:WIDTH];
          w_lo_nxt = w_fix_prod[WIDTH-1:0];
        end
        w_busy_nxt  = 1'b0;
        w_done_nxt  = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_acc     <= '0;
      r_opnd    <= '0;
      r_sign_lo <= 1'b0;
      r_sign_hi <= 1'b0;
      r_is_div  <= 1'b0;
      r_divz    <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_acc     <= w_acc_nxt;
      r_opnd    <= w_opnd_nxt;
      r_sign_lo <= w_sign_lo_nxt;
      r_sign_hi <= w_sign_hi_nxt;
      r_is_div  <= w_is_div_nxt;
      r_divz    <= w_divz_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
      r_hi      <= w_hi_nxt;
      r_lo      <= w_lo_nxt;
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.hi   = r_hi;
  assign bus.lo   = r_lo;

endmodule
